// File: rtl/fir_output_requantizer.sv
// ============================================================================
// fir_output_requantizer
//
// Purpose:
//   Takes the wide signed accumulator output of a FIR filter, optionally
//   decimates it, rounds away SHIFT fractional bits (round-half-up), clamps the
//   result to a signed OUT_WIDTH sample and buffers it in a small show-ahead
//   FIFO for a downstream consumer with valid/ready flow control.
//
//   Pipeline:
//     din_valid (cycle N) -> stage 1 rounding register (N+1)
//                         -> stage 2 saturation register (N+2, FIFO write)
//                         -> FIFO head visible on dout (N+3 when idle)
//
// Parameters:
//   IN_WIDTH    signed width of the incoming accumulator sample
//   OUT_WIDTH   signed width of the requantized output sample
//   SHIFT       number of fractional bits removed (>= 1)
//   DECIM       decimation factor, 1..64 (1 keeps every sample)
//   FIFO_DEPTH  output FIFO depth, power of two >= 2
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   din         signed wide sample
//   din_valid   din qualifier; upstream cannot be stalled
//   dout        signed FIFO head sample (0 while the FIFO is empty)
//   dout_valid  high whenever the FIFO holds at least one sample
//   dout_ready  downstream accept; transfer when dout_valid && dout_ready
//   clr_flags   clears sat_flag, drop_flag and drop_count
//   sat_flag    sticky: a sample was clamped
//   drop_flag   sticky: a sample was discarded because the FIFO was full
//   drop_count  number of discarded samples, saturating at 65535
// ============================================================================
module fir_output_requantizer #(
    parameter int IN_WIDTH   = 39,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 din_valid,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    input  logic                 clr_flags,
    output logic                 sat_flag,
    output logic                 drop_flag,
    output logic [15:0]          drop_count
);

    // ------------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------------
    localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    // One guard bit above the input so the rounding add can never wrap.
    localparam int RW      = IN_WIDTH + 1;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

    // Rounding constant 2^(SHIFT-1) at the guarded width.
    localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);

    // Output range limits, sign-extended to the guarded width for comparison.
    localparam logic signed [RW-1:0] MAX_R =
        {{(RW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_R =
        {{(RW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    localparam logic [OUT_WIDTH-1:0] MAX_OUT = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_OUT = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // Decimation phase counter
    // ------------------------------------------------------------------------
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    logic               keep;

    always_comb begin
        phase_d = phase_q;
        if (din_valid) begin
            if (phase_q == PHASE_LAST) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end
    end

    // With DECIM=1 PHASE_LAST is 0, so the phase never leaves 0.
    assign keep = din_valid && (phase_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: round-half-up and arithmetic shift
    // ------------------------------------------------------------------------
    logic signed [RW-1:0] din_ext;
    logic signed [RW-1:0] rnd_sum;
    logic signed [RW-1:0] rnd_shift;
    logic                 s1_valid_q;
    logic signed [RW-1:0] s1_r_q;

    assign din_ext   = {din[IN_WIDTH-1], din};
    assign rnd_sum   = din_ext + HALF;
    assign rnd_shift = rnd_sum >>> SHIFT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
        end else begin
            s1_valid_q <= keep;
            if (keep) begin
                s1_r_q <= rnd_shift;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: clamp to the output range
    // ------------------------------------------------------------------------
    logic                 sat_hi;
    logic                 sat_lo;
    logic                 sat_event;
    logic [OUT_WIDTH-1:0] s2_data_d;
    logic                 s2_valid_q;
    logic [OUT_WIDTH-1:0] s2_data_q;

    assign sat_hi    = (s1_r_q > MAX_R);
    assign sat_lo    = (s1_r_q < MIN_R);
    assign sat_event = s1_valid_q && (sat_hi || sat_lo);

    always_comb begin
        s2_data_d = s1_r_q[OUT_WIDTH-1:0];
        if (sat_hi) begin
            s2_data_d = MAX_OUT;
        end else if (sat_lo) begin
            s2_data_d = MIN_OUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Show-ahead output FIFO
    //   Occupancy counter is one bit wider than the pointers so that full and
    //   empty are distinguishable. A write into a full FIFO succeeds only when
    //   a read frees a slot in the same cycle; otherwise the sample is dropped.
    // ------------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW-1:0]        rd_ptr_d;
    logic [AW:0]          count_q;
    logic [AW:0]          count_d;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 rd_en;
    logic                 wr_en;
    logic                 drop_event;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    // A read needs a valid head, so with an empty FIFO only the write happens.
    assign rd_en      = !fifo_empty && dout_ready;
    assign wr_en      = s2_valid_q && (!fifo_full || rd_en);
    assign drop_event = s2_valid_q && fifo_full && !rd_en;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale contents are never visible because dout is
    // forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s2_data_q;
        end
    end

    assign dout_valid = !fifo_empty;
    assign dout       = fifo_empty ? '0 : mem_q[rd_ptr_q];

    // ------------------------------------------------------------------------
    // Sticky status flags and drop counter
    //   A new event in the same cycle as clr_flags wins: the flag stays set
    //   and the counter restarts at 1.
    // ------------------------------------------------------------------------
    logic        sat_flag_q;
    logic        sat_flag_d;
    logic        drop_flag_q;
    logic        drop_flag_d;
    logic [15:0] drop_count_q;
    logic [15:0] drop_count_d;

    always_comb begin
        sat_flag_d   = sat_flag_q;
        drop_flag_d  = drop_flag_q;
        drop_count_d = drop_count_q;

        if (sat_event) begin
            sat_flag_d = 1'b1;
        end else if (clr_flags) begin
            sat_flag_d = 1'b0;
        end

        if (drop_event) begin
            drop_flag_d = 1'b1;
            if (clr_flags) begin
                drop_count_d = 16'd1;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end else if (clr_flags) begin
            drop_flag_d  = 1'b0;
            drop_count_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_flag_q   <= 1'b0;
            drop_flag_q  <= 1'b0;
            drop_count_q <= 16'd0;
        end else begin
            sat_flag_q   <= sat_flag_d;
            drop_flag_q  <= drop_flag_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign sat_flag   = sat_flag_q;
    assign drop_flag  = drop_flag_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fir_output_requantizer.sv
// ============================================================================
// tb_fir_output_requantizer
//
// Directed, table-driven bench for fir_output_requantizer. One instance runs
// with DECIM=1 (rounding, saturation, FIFO behaviour, reset); a second runs
// with DECIM=4 (decimation and phase reset). Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
// ============================================================================
module tb_fir_output_requantizer;

    localparam int IN_W  = 39;
    localparam int OUT_W = 16;

    typedef struct {
        longint din;
        longint exp_dout;
        bit     exp_sat;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;

    // DECIM=1 instance
    logic [IN_W-1:0]  din = '0;
    logic             din_valid = 1'b0;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             clr_flags = 1'b0;
    logic             sat_flag;
    logic             drop_flag;
    logic [15:0]      drop_count;

    // DECIM=4 instance
    logic [IN_W-1:0]  din4 = '0;
    logic             din4_valid = 1'b0;
    logic [OUT_W-1:0] dout4;
    logic             dout4_valid;
    logic             dout4_ready = 1'b1;
    logic             clr4_flags = 1'b0;
    logic             sat4_flag;
    logic             drop4_flag;
    logic [15:0]      drop4_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fir_output_requantizer #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT(15), .DECIM(1), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .clr_flags(clr_flags), .sat_flag(sat_flag), .drop_flag(drop_flag),
        .drop_count(drop_count)
    );

    fir_output_requantizer #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT(15), .DECIM(4), .FIFO_DEPTH(8)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(din4_valid),
        .dout(dout4), .dout_valid(dout4_valid), .dout_ready(dout4_ready),
        .clr_flags(clr4_flags), .sat_flag(sat4_flag), .drop_flag(drop4_flag),
        .drop_count(drop4_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
            $display("ok   %s: got %0d", name, act);
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    vec_t vecs[13];
    int   q[$];

    initial begin
        // Hand-computed: r = floor((din + 16384) / 32768), clamped to int16.
        vecs[0]  = '{64'sd3276800,        64'sd100,    1'b0};
        vecs[1]  = '{64'sd16384,          64'sd1,      1'b0};
        vecs[2]  = '{-64'sd16384,         64'sd0,      1'b0};
        vecs[3]  = '{64'sd16383,          64'sd0,      1'b0};
        vecs[4]  = '{-64'sd16385,         -64'sd1,     1'b0};
        vecs[5]  = '{64'sd1073709056,     64'sd32767,  1'b0};
        vecs[6]  = '{64'sd1073725440,     64'sd32767,  1'b1};
        vecs[7]  = '{-64'sd1073741824,    -64'sd32768, 1'b0};
        vecs[8]  = '{-64'sd1073758209,    -64'sd32768, 1'b1};
        vecs[9]  = '{64'sd2147483648,     64'sd32767,  1'b1};
        vecs[10] = '{64'sd274877906943,   64'sd32767,  1'b1};
        vecs[11] = '{-64'sd2147483648,    -64'sd32768, 1'b1};
        vecs[12] = '{-64'sd274877906944,  -64'sd32768, 1'b1};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset dout_valid", longint'(dout_valid), 0);
        chk("reset dout", longint'(dout), 0);
        chk("reset sat_flag", longint'(sat_flag), 0);
        chk("reset drop_flag", longint'(drop_flag), 0);
        chk("reset drop_count", longint'(drop_count), 0);
        rst_n = 1'b1;
        tick();

        // ---------------- DECIM=4: keep every 4th sample ----------------
        q.delete();
        for (int c = 0; c < 30; c++) begin
            din4_valid = (c < 12);
            din4 = IN_W'(longint'(c) * 32768);
            if (dout4_valid) q.push_back(int'($signed(dout4)));
            tick();
        end
        din4_valid = 1'b0;
        chk("decim4 output count", q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("decim4 out[%0d]", k), (k < q.size()) ? q[k] : -999, 4 * k);
        end

        // ---------------- DECIM=4: phase restarts at 0 after reset ----------------
        din4 = IN_W'(1 * 32768); din4_valid = 1'b1; tick();
        din4 = IN_W'(2 * 32768); din4_valid = 1'b1; tick();
        din4_valid = 1'b0; rst_n = 1'b0; tick();
        rst_n = 1'b1;
        din4 = IN_W'(7 * 32768); din4_valid = 1'b1;
        q.delete();
        for (int c = 0; c < 8; c++) begin
            if (dout4_valid) q.push_back(int'($signed(dout4)));
            tick();
            din4_valid = 1'b0;
        end
        chk("phase reset output count", q.size(), 1);
        chk("phase reset first kept", (q.size() > 0) ? q[0] : -999, 7);

        // ---------------- rounding / saturation table (DECIM=1) ----------------
        dout_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            din = IN_W'(vecs[i].din);
            din_valid = 1'b1;
            clr_flags = 1'b1;
            tick();                                   // cycle 1
            din_valid = 1'b0;
            clr_flags = 1'b0;
            tick();                                   // cycle 2
            chk($sformatf("vec%0d valid low at N+2", i), longint'(dout_valid), 0);
            tick();                                   // cycle 3
            chk($sformatf("vec%0d valid at N+3", i), longint'(dout_valid), 1);
            chk($sformatf("vec%0d dout", i), longint'($signed(dout)), vecs[i].exp_dout);
            chk($sformatf("vec%0d sat_flag", i), longint'(sat_flag), longint'(vecs[i].exp_sat));
            tick();                                   // accepted at end of cycle 3
            chk($sformatf("vec%0d popped", i), longint'(dout_valid), 0);
        end

        // clr_flags clears a set sat_flag
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("sat_flag cleared", longint'(sat_flag), 0);

        // ---------------- overflow: 10 samples into depth-8 FIFO ----------------
        dout_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            din = IN_W'(longint'(c + 1) * 32768);
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        repeat (3) tick();
        chk("full dout_valid", longint'(dout_valid), 1);
        chk("full head", longint'($signed(dout)), 1);
        chk("full drop_count", longint'(drop_count), 2);
        chk("full drop_flag", longint'(drop_flag), 1);
        chk("full sat_flag", longint'(sat_flag), 0);

        // drop and clr_flags in the same cycle: event wins, counter restarts at 1
        din = IN_W'(11 * 32768); din_valid = 1'b1; tick();
        din_valid = 1'b0; tick();
        clr_flags = 1'b1; tick();
        clr_flags = 1'b0;
        chk("clr+drop drop_count", longint'(drop_count), 1);
        chk("clr+drop drop_flag", longint'(drop_flag), 1);
        chk("head held while stalled", longint'($signed(dout)), 1);

        // drain
        dout_ready = 1'b1;
        q.delete();
        for (int c = 0; c < 12; c++) begin
            if (dout_valid) q.push_back(int'($signed(dout)));
            tick();
        end
        chk("drain count", q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain[%0d]", k), (k < q.size()) ? q[k] : -999, k + 1);
        end
        chk("drained dout_valid", longint'(dout_valid), 0);

        // ---------------- full FIFO with simultaneous read and write ----------------
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("pre-stream drop_count", longint'(drop_count), 0);
        for (int c = 0; c < 20; c++) begin
            din = IN_W'(longint'(20 + c) * 32768);
            din_valid = 1'b1;
            dout_ready = (c >= 10);
            if (c >= 10) begin
                chk($sformatf("stream c%0d valid", c), longint'(dout_valid), 1);
                chk($sformatf("stream c%0d dout", c), longint'($signed(dout)), 20 + (c - 10));
            end
            tick();
        end
        chk("stream drop_count", longint'(drop_count), 0);
        chk("stream drop_flag", longint'(drop_flag), 0);

        // one-cycle reset mid-stream
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        din_valid = 1'b0;
        chk("midreset dout_valid", longint'(dout_valid), 0);
        chk("midreset dout", longint'(dout), 0);
        chk("midreset sat_flag", longint'(sat_flag), 0);
        chk("midreset drop_flag", longint'(drop_flag), 0);
        chk("midreset drop_count", longint'(drop_count), 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("midreset flushed c%0d", c), longint'(dout_valid), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fir_output_requantizer.md
FIR_OUTPUT_REQUANTIZER -- requirements
Module: fir_output_requantizer

Interface
REQ-001 Parameter IN_WIDTH, default 39, SHALL be the signed width of the wide filter accumulator sample.
REQ-002 Parameter OUT_WIDTH, default 16, SHALL be the signed width of the requantized output sample.
REQ-003 Parameter SHIFT, default 15, SHALL be the number of fractional bits removed (Q1.15 coefficients).
REQ-004 Parameter DECIM, default 1, range 1..64, SHALL be the decimation factor.
REQ-005 Parameter FIFO_DEPTH, default 8, power of two >= 2, SHALL be the output FIFO depth.
REQ-006 clk  input  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-007 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-008 din  input  IN_WIDTH  SHALL carry the signed wide sample.
REQ-009 din_valid  input  1  SHALL mark din valid this cycle; there is no upstream backpressure.
REQ-010 dout  output  OUT_WIDTH  SHALL present the signed FIFO head sample.
REQ-011 dout_valid  output  1  SHALL be high whenever the FIFO is non-empty.
REQ-012 dout_ready  input  1  SHALL be the downstream accept; a transfer occurs when dout_valid && dout_ready.
REQ-013 clr_flags  input  1  SHALL clear the sticky flags and counter.
REQ-014 sat_flag  output  1  SHALL be a sticky flag indicating saturation occurred.
REQ-015 drop_flag  output  1  SHALL be a sticky flag indicating a sample was dropped on FIFO full.
REQ-016 drop_count  output  16  SHALL count dropped samples, saturating at 65535.

Function
REQ-017 Decimation: a phase counter SHALL advance 0..DECIM-1 on each din_valid and wrap; a sample SHALL be kept only when the phase equals 0; DECIM=1 SHALL keep every sample.
REQ-018 Stage 1 (registered): rounding SHALL be r = (din + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, round-half-up, computed at IN_WIDTH+1 bits so that the rounding add never wraps.
REQ-019 Stage 2 (registered): if r > 2^(OUT_WIDTH-1)-1, the result SHALL be that maximum; if r < -2^(OUT_WIDTH-1), the result SHALL be that minimum; either case SHALL set sat_flag.
REQ-020 Stage 2 output valid SHALL write the FIFO; din_valid in cycle N SHALL give a FIFO write in cycle N+2.
REQ-021 With the FIFO empty and no stall, dout_valid SHALL rise in cycle N+3.
REQ-022 The FIFO SHALL be show-ahead: dout SHALL equal the oldest entry while dout_valid is high, and dout SHALL be held stable until it is accepted.
REQ-023 On a write with the FIFO full and no simultaneous read, the new sample SHALL be discarded, drop_flag SHALL be set, and drop_count SHALL increment.
REQ-024 On a write with the FIFO full and a simultaneous read, both operations SHALL succeed and the occupancy SHALL remain FIFO_DEPTH.
REQ-025 On a simultaneous read and write with the FIFO empty, only the write SHALL take effect, because dout_valid is low.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; the full and empty conditions SHALL use an extra pointer bit or an occupancy counter of log2(FIFO_DEPTH)+1 bits.
REQ-027 If clr_flags and a saturation or drop event occur in the same cycle, the event SHALL take priority: the flag is set and drop_count becomes 1.
REQ-028 Pipeline and FIFO operation SHALL be independent of clr_flags.

Reset
REQ-029 While rst_n is low at a clock edge, the block SHALL clear the phase counter, the stage valids, and the FIFO pointers and occupancy.
REQ-030 Reset SHALL drive dout=0, dout_valid=0, sat_flag=0, drop_flag=0 and drop_count=0.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight and buffered samples, with no output transfer in the cycle after reset.
REQ-032 After rst_n returns high, the first din_valid SHALL be at phase 0 and therefore kept.

Verification
REQ-033 SHIFT=15, DECIM=1: din=3276800 pulsed at cycle 0 with dout_ready=1 -> dout=100 with dout_valid high at cycle 3; sat_flag=0.
REQ-034 Rounding: din=16384 -> dout=1; din=-16384 -> dout=0; din=16383 -> dout=0; din=-16385 -> dout=-1.
REQ-035 Saturation: din=2^31 -> dout=32767; din=-2^31 -> dout=-32768; sat_flag=1 after each; clr_flags pulse -> sat_flag=0.
REQ-036 DECIM=4, 12 consecutive valids of din=k*32768 (k=0..11) -> outputs exactly 0, 4, 8 in order.
REQ-037 FIFO_DEPTH=8, dout_ready=0, 10 kept samples -> 8 buffered, drop_count=2, drop_flag=1; then dout_ready=1 -> the first 8 values drain in order and dout_valid falls.
REQ-038 FIFO full while dout_ready=1 and din_valid=1 continuously -> one transfer per cycle, no drops; rst_n low for one cycle mid-stream -> dout_valid=0 and all flags and counters 0 on the next cycle.
